// File: rtl/config.svh
// Word-width configuration shared by the matrix adder datapath.
`ifndef N
`define N 16
`endif

// File: rtl/matrix_add_stream.sv
// Row-serial handshaked signed-magnitude matrix adder/subtractor with one registered output row.
// Optional build macro MATADD_SAT_EN: saturate overflowing lane magnitudes instead of wrapping.
`include "config.svh"

module matrix_add_stream #(
  parameter int R = 3,
  parameter int C = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sub,
  input  logic [`N*C-1:0]      a_row,
  input  logic [`N*C-1:0]      b_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [`N*C-1:0]      c_row,
  output logic [((R > 1) ? $clog2(R) : 1)-1:0] out_row_idx,
  output logic                 out_last,
  output logic [C-1:0]         out_ovf,
  output logic                 busy
);

  localparam int NW = `N;
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  logic [IW-1:0]   row_cnt;
  logic            mode;
  logic            in_xfer;
  logic            row_sub;
  logic            row_last;
  logic [NW*C-1:0] nxt_c;
  logic [C-1:0]    nxt_ovf;

  // Returns {overflow, result word} for one lane.
  function automatic logic [NW:0] lane_op(input logic [NW-1:0] a,
                                          input logic [NW-1:0] b,
                                          input logic          sub);
    logic          sa, sb, sr, ovf;
    logic [NW-2:0] ma, mb, mr;
    logic [NW-1:0] sum;
    sa  = a[NW-1];
    sb  = b[NW-1] ^ sub;
    ma  = a[NW-2:0];
    mb  = b[NW-2:0];
    ovf = 1'b0;
    sum = '0;
    if (sa == sb) begin
      sum = {1'b0, ma} + {1'b0, mb};
      ovf = sum[NW-1];
      sr  = sa;
`ifdef MATADD_SAT_EN
      mr  = ovf ? '1 : sum[NW-2:0];
`else
      mr  = sum[NW-2:0];
`endif
    end else if (ma >= mb) begin
      mr = ma - mb;
      sr = sa;
    end else begin
      mr = mb - ma;
      sr = sb;
    end
    // A zero magnitude is always encoded as +0.
    if (mr == '0) sr = 1'b0;
    return {ovf, sr, mr};
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign row_sub  = (row_cnt == '0) ? in_sub : mode;
  assign row_last = (row_cnt == IW'(R - 1));
  assign busy     = (row_cnt != '0);

  always_comb begin
    logic [NW:0] r;
    nxt_c   = '0;
    nxt_ovf = '0;
    r       = '0;
    for (int j = 0; j < C; j++) begin
      r                = lane_op(a_row[j*NW +: NW], b_row[j*NW +: NW], row_sub);
      nxt_c[j*NW +: NW] = r[NW-1:0];
      nxt_ovf[j]       = r[NW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt     <= '0;
      mode        <= 1'b0;
      out_valid   <= 1'b0;
      c_row       <= '0;
      out_row_idx <= '0;
      out_last    <= 1'b0;
      out_ovf     <= '0;
    end else begin
      if (in_xfer) begin
        if (row_cnt == '0) mode <= in_sub;
        row_cnt     <= row_last ? '0 : row_cnt + 1'b1;
        out_valid   <= 1'b1;
        c_row       <= nxt_c;
        out_row_idx <= row_cnt;
        out_last    <= row_last;
        out_ovf     <= nxt_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_add_stream.sv
// Directed self-checking bench for matrix_add_stream (N=16, R=3, C=4).
module tb_matrix_add_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sub;
  logic [63:0] a_row;
  logic [63:0] b_row;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] c_row;
  logic [1:0]  out_row_idx;
  logic        out_last;
  logic [3:0]  out_ovf;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  matrix_add_stream #(.R(3), .C(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .a_row(a_row), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
    .c_row(c_row), .out_row_idx(out_row_idx), .out_last(out_last), .out_ovf(out_ovf),
    .busy(busy)
  );

  function automatic logic [63:0] rep(input logic [15:0] w);
    return {4{w}};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sub = 1'b0;
    a_row = '0;
    b_row = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offers one row, waits for the transfer edge, returns 1 ns after it.
  task automatic send_row(input logic [63:0] a, input logic [63:0] b, input logic sub);
    bit ok;
    int guard;
    a_row = a;
    b_row = b;
    in_sub = sub;
    in_valid = 1'b1;
    ok = 0;
    guard = 0;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_row_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (c_row !== 64'h0) $display("FAIL reset_c_row: got %h want 0", c_row); else n_pass++;
    n_total++; if ({out_row_idx, out_last, out_ovf} !== 7'h0) $display("FAIL reset_tags: got idx=%0d last=%b ovf=%b want 0", out_row_idx, out_last, out_ovf); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_add();
    do_reset();
    a_row = rep(16'h0100);
    b_row = rep(16'h0180);
    in_sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL add_pre_edge_valid: got %b want 0", out_valid); else n_pass++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL add_latency: out_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (c_row !== rep(16'h0280)) $display("FAIL add_c_row: got %h want %h", c_row, rep(16'h0280)); else n_pass++;
    n_total++; if (out_ovf !== 4'b0000 || out_row_idx !== 2'd0 || out_last !== 1'b0) $display("FAIL add_tags: got ovf=%b idx=%0d last=%b want 0000/0/0", out_ovf, out_row_idx, out_last); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL add_busy: got %b want 1", busy); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL add_drain: out_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_mixed_sign();
    do_reset();
    send_row({16'h0100, 16'h0100, 16'h8000, 16'h8000},
             {16'h8180, 16'h8100, 16'h8000, 16'h0000}, 1'b0);
    n_total++; if (c_row !== {16'h8080, 16'h0000, 16'h0000, 16'h0000}) $display("FAIL mixed_c_row: got %h want 8080000000000000", c_row); else n_pass++;
    n_total++; if (out_ovf !== 4'b0000) $display("FAIL mixed_ovf: got %b want 0000", out_ovf); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [63:0] exp_c;
`ifdef MATADD_SAT_EN
    exp_c = {16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h7FFF};
`else
    exp_c = {16'h7FFF, 16'h0000, 16'h8100, 16'h0100};
`endif
    do_reset();
    send_row({16'h7F00, 16'h7F00, 16'hFF00, 16'h7F00},
             {16'h00FF, 16'h0100, 16'h8200, 16'h0200}, 1'b0);
    n_total++; if (c_row !== exp_c) $display("FAIL ovf_c_row: got %h want %h", c_row, exp_c); else n_pass++;
    n_total++; if (out_ovf !== 4'b0111) $display("FAIL ovf_flags: got %b want 0111", out_ovf); else n_pass++;
  endtask

  // Back-to-back rows with the mode latched on row 0 of each matrix.
  task automatic test_back_to_back_mode();
    logic [15:0] av [4] = '{16'h0300, 16'h0050, 16'h8100, 16'h0300};
    logic [15:0] bv [4] = '{16'h0100, 16'h0100, 16'h8200, 16'h0100};
    logic        sv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] ev [4] = '{16'h0200, 16'h80B0, 16'h0100, 16'h0400};
    logic [1:0]  iv [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic        lv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_row(rep(av[i]), rep(bv[i]), sv[i]);
      n_total++; if (out_valid !== 1'b1 || c_row !== rep(ev[i])) $display("FAIL mode_row%0d_c: got v=%b c=%h want v=1 c=%h", i, out_valid, c_row, rep(ev[i])); else n_pass++;
      n_total++; if (out_row_idx !== iv[i] || out_last !== lv[i]) $display("FAIL mode_row%0d_tags: got idx=%0d last=%b want idx=%0d last=%b", i, out_row_idx, out_last, iv[i], lv[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_row({16'(i*16+3), 16'(i*16+2), 16'(i*16+1), 16'(i*16)}, rep(16'h0001), 1'b0);
      end
      begin
        bit          prev_stall = 0;
        logic [63:0] prev_c = '0;
        logic [63:0] exp_c;
        int          cyc = 0;
        while (got < 6 && cyc < 300) begin
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (prev_stall) begin
            n_total++; if (out_valid !== 1'b1 || c_row !== prev_c) $display("FAIL bp_hold: got v=%b c=%h want v=1 c=%h", out_valid, c_row, prev_c); else n_pass++;
          end
          if (out_valid && !out_ready) begin
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0 while stalled", in_ready); else n_pass++;
          end
          if (out_valid && out_ready) begin
            exp_c = {16'(got*16+4), 16'(got*16+3), 16'(got*16+2), 16'(got*16+1)};
            n_total++; if (c_row !== exp_c || out_row_idx !== 2'(got % 3) || out_last !== (got % 3 == 2)) $display("FAIL bp_row%0d: got c=%h idx=%0d last=%b want c=%h idx=%0d last=%b", got, c_row, out_row_idx, out_last, exp_c, got % 3, got % 3 == 2); else n_pass++;
            got++;
          end
          prev_stall = out_valid && !out_ready;
          prev_c = c_row;
          @(posedge clk);
          #1;
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
    n_total++; if (got !== 6) $display("FAIL bp_count: got %0d rows want 6", got); else n_pass++;
  endtask

  task automatic test_reset_mid_matrix();
    do_reset();
    send_row(rep(16'h0100), rep(16'h0100), 1'b0);
    send_row(rep(16'h0100), rep(16'h0100), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_total++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL midrst_state: got busy=%b v=%b want 0/0", busy, out_valid); else n_pass++;
    send_row(rep(16'h0300), rep(16'h0100), 1'b1);
    n_total++; if (out_row_idx !== 2'd0 || c_row !== rep(16'h0200)) $display("FAIL midrst_row0: got idx=%0d c=%h want idx=0 c=%h", out_row_idx, c_row, rep(16'h0200)); else n_pass++;
    send_row(rep(16'h0300), rep(16'h0100), 1'b0);
    n_total++; if (out_row_idx !== 2'd1 || c_row !== rep(16'h0200)) $display("FAIL midrst_row1: got idx=%0d c=%h want idx=1 c=%h", out_row_idx, c_row, rep(16'h0200)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mixed_sign();
    test_overflow();
    test_back_to_back_mode();
    test_backpressure();
    test_reset_mid_matrix();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/matrix_add_stream.md
# matrix_add_stream

Row-serial, handshaked fixed-point matrix adder/subtractor for R×C matrices of `N`-bit signed-magnitude words. It accepts one row of operands A and B per beat, produces one registered result row per beat with row index, last-row marker and overflow flags, and latches the add/subtract mode per matrix. It sits between the weight/activation row streamers and the layer-output buffer in the MLP feed-forward datapath, replacing the fully parallel combinational adder array where area matters.

## Interface
- R, 3, rows per matrix (≥1)
- C, 4, columns per row = lanes processed in parallel (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand row valid
- in_ready  out  1  block can accept an operand row
- in_sub  in  1  0: A+B, 1: A−B; sampled only on row 0 of a matrix
- a_row  in  `N`×C  row of A, lane j = column j
- b_row  in  `N`×C  row of B
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts result row
- c_row  out  `N`×C  result row
- out_row_idx  out  $clog2(R) (min 1)  row index of c_row
- out_last  out  1  c_row is row R−1
- out_ovf  out  C  per-lane magnitude overflow on this row
- busy  out  1  a matrix is partially accepted (row counter ≠ 0)

Word width `N` comes from `config.svh`; sign is bit `N`−1, magnitude bits `N`−2:0.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready (single output register, full throughput).
- Row counter: 0..R−1, +1 per input transfer, wraps to 0 after R−1. busy = (counter ≠ 0).
- Mode: on transfer with counter = 0, mode register ← in_sub and that row uses in_sub; rows 1..R−1 use the mode register. in_sub ignored on other rows.
- Per lane: b' = b with sign inverted if subtracting.
  - Signs equal: magnitude = |a|+|b'|, sign = sign(a). Carry out of bit `N`−2 sets out_ovf[j].
  - Signs differ: magnitude = larger − smaller, sign = sign of larger magnitude; never overflows.
  - Zero magnitude result always encoded +0 (sign 0), including −0 inputs.
- out_row_idx/out_last reflect the counter value at the input transfer that produced the row.
- Output register holds c_row and all tags stable while out_valid && !out_ready.

## Timing
- Latency 1 cycle: row accepted at edge k is on c_row with out_valid high after edge k.
- Back-to-back: one row per cycle when out_ready held high.
- Backpressure: out_ready low with out_valid high → in_ready low same cycle; no row dropped or duplicated.
- Simultaneous output and input transfer in one cycle: register reloads with new row, out_valid stays 1.
- Reset: out_valid=0, c_row=0, out_row_idx=0, out_last=0, out_ovf=0, busy=0, counter=0, mode=0; in_ready=1 during the cycle after reset. Reset mid-matrix discards the partial matrix; the next accepted row is row 0.

## Configuration
- MATADD_SAT_EN defined: on overflow the lane magnitude saturates to all ones (max representable), sign preserved.
- Undefined: magnitude wraps (carry dropped). out_ovf reports overflow identically in both builds.

## Test plan
Values with `N`=16 (F=8), R=3, C=4.
- Add: a=0x0100 (+1.0), b=0x0180 (+1.5), in_sub=0 → c=0x0280, out_ovf=0, latency 1.
- Mixed sign/zero: a=0x0100, b=0x8180 → 0x8080; a=0x0100, b=0x8100 → 0x0000 (not 0x8000).
- Overflow: a=0x7F00, b=0x0200 → with MATADD_SAT_EN 0x7FFF, without 0x0100; out_ovf lane bit =1 both builds.
- Mode latch: row 0 in_sub=1 (a=0x0300, b=0x0100 → 0x0200); rows 1–2 with in_sub=0 still subtract; out_last only on row 2, idx 0,1,2 then wraps to 0.
- Backpressure: stream 6 rows, out_ready random 50% → all 6 rows out in order, c_row stable while stalled, in_ready=0 whenever out_valid && !out_ready.
- Reset after row 1 accepted → busy=0, out_valid=0; next row accepted reports out_row_idx=0 and resamples in_sub.
